mem_slot_arbiter: RTL
=====================

Name: mem_slot_arbiter

Overview:
- Time-division arbiter for the shared 32K system RAM between the video address generator (CRTC-driven fetches) and the 6502 CPU port.
- Runs on the 100 MHz system clock; an external divider supplies a one-cycle slot strobe (SLOT_EN).
- Slots strictly alternate VIDEO, CPU, VIDEO, CPU. Each slot issues one RAM access and returns data after a fixed RAM latency.
- Sits between the CPU/CRTC interfaces and the block-RAM wrapper inside TOP.

Parameters:
- ADDR_W, 15, RAM address width (bits).
- DATA_W, 8, RAM data width (bits).
- RAM_LATENCY, 1, cycles from address presented to RAM_DOUT valid (1..7).

Ports:
- CLK100MHZ  in  1  system clock, all logic on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- SLOT_EN  in  1  one-cycle strobe starting a new slot.
- CPU_REQ  in  1  CPU access request; held high until CPU_ACK.
- CPU_WE  in  1  1 = write, 0 = read; sampled at slot start.
- CPU_ADDR  in  ADDR_W  CPU address; sampled at slot start.
- CPU_DIN  in  DATA_W  CPU write data; sampled at slot start.
- CPU_DOUT  out  DATA_W  CPU read data; valid from the CPU_ACK cycle until the next CPU read completes.
- CPU_ACK  out  1  one-cycle pulse when the CPU access completes.
- VID_ADDR  in  ADDR_W  video fetch address; sampled at slot start.
- VID_DOUT  out  DATA_W  fetched video byte.
- VID_VALID  out  1  one-cycle pulse when VID_DOUT is updated.
- CPU_SLOT  out  1  level, high for the whole duration of a CPU slot (CPU phase indicator).
- RAM_ADDR  out  ADDR_W  RAM address.
- RAM_WE  out  1  RAM write enable.
- RAM_DIN  out  DATA_W  RAM write data.
- RAM_DOUT  in  DATA_W  RAM read data.
- OVERRUN  out  1  sticky; set when SLOT_EN arrives before the current access completes.

Behaviour:
- Reset (async, immediate): state IDLE, next-owner = VIDEO. All outputs = 0, including CPU_DOUT, VID_DOUT and OVERRUN.
- States: IDLE, ACCESS, WAIT.
- Any state, SLOT_EN=1:
  - Owner = next-owner; next-owner toggles.
  - Latency counter loads RAM_LATENCY.
  - Go to ACCESS.
- VIDEO slot start: RAM_ADDR <= VID_ADDR, RAM_WE <= 0, CPU_SLOT <= 0.
- CPU slot start: CPU_SLOT <= 1.
  - CPU_REQ=1: RAM_ADDR <= CPU_ADDR, RAM_DIN <= CPU_DIN, RAM_WE <= CPU_WE.
  - CPU_REQ=0: idle slot; RAM_WE <= 0, no ACK, state returns to IDLE next cycle, CPU_SLOT stays high until the next SLOT_EN.
- ACCESS (1 cycle): RAM_WE forced to 0 on exit, so a write is exactly one cycle wide. Go to WAIT.
- WAIT: counter decrements each cycle. The transition out of WAIT happens when the counter reaches 0 (RAM_LATENCY cycles after the ACCESS cycle); on that transition:
  - VIDEO slot: VID_DOUT <= RAM_DOUT, VID_VALID = 1 for one cycle.
  - CPU read: CPU_DOUT <= RAM_DOUT, CPU_ACK = 1 for one cycle.
  - CPU write: CPU_ACK = 1 for one cycle, CPU_DOUT unchanged.
  - Then go to IDLE.
- Latency: SLOT_EN to VID_VALID/CPU_ACK = RAM_LATENCY+2 cycles.
- Slot period (cycles between consecutive SLOT_EN pulses) must be >= RAM_LATENCY+3.
- SLOT_EN while in ACCESS or WAIT:
  - OVERRUN <= 1 (sticky until RESET).
  - Current access is abandoned: no VALID/ACK for it.
  - New slot starts normally.
- CPU_REQ rising mid-slot is not serviced until the next CPU slot. RAM_ADDR holds its last value in IDLE.
- CPU_SLOT changes only on SLOT_EN or RESET.

Optional Feature:
- Macro ARB_DBG_PORT_EN.
- Defined:
  - Adds ports DBG_REQ (in 1), DBG_WE (in 1), DBG_ADDR (in ADDR_W), DBG_DIN (in DATA_W), DBG_DOUT (out DATA_W), DBG_ACK (out 1).
  - A CPU slot with CPU_REQ=0 and DBG_REQ=1 is given to the debug port, with identical timing, using DBG_DOUT/DBG_ACK.
  - CPU_SLOT still reads high during such a slot.
  - CPU always wins if both request.
- Undefined: ports absent; idle CPU slots stay idle.

Test Plan:
- Reset with RESET=1 mid-WAIT -> all outputs 0 within the same cycle; first slot after release is VIDEO (CPU_SLOT=0).
- RAM_LATENCY=1, SLOT_EN every 8 cycles, VID_ADDR=15'h3000, RAM model returns 8'hA5 -> VID_VALID pulses 3 cycles after SLOT_EN with VID_DOUT=8'hA5; next slot CPU_SLOT=1.
- CPU write CPU_ADDR=15'h0100, CPU_DIN=8'h5C, then read of same address -> RAM_WE high exactly one cycle with RAM_ADDR=15'h0100 and RAM_DIN=8'h5C; read returns CPU_DOUT=8'h5C with single-cycle CPU_ACK.
- CPU_REQ=0 over 4 consecutive CPU slots -> no CPU_ACK, RAM_WE stays 0, VIDEO slots unaffected (4 VID_VALID pulses).
- SLOT_EN period 2 cycles with RAM_LATENCY=1 -> OVERRUN=1 and stays 1; no VID_VALID/CPU_ACK for the aborted slot.
- With ARB_DBG_PORT_EN: DBG_REQ=1, CPU_REQ=0, DBG read at 15'h7FFF returning 8'h3E -> DBG_ACK pulse, DBG_DOUT=8'h3E; with CPU_REQ=1 in the same slot, CPU is served and DBG_ACK stays 0.

Source files
------------

// File: rtl/mem_slot_arbiter.sv
// mem_slot_arbiter: alternates VIDEO / CPU slots on the shared system RAM.
// Latency: SLOT_EN to VID_VALID / CPU_ACK is RAM_LATENCY+2 cycles.
// Backpressure: none; CPU_REQ is held until CPU_ACK, and a SLOT_EN that
//   arrives before the current access finishes aborts it and sets OVERRUN.
//
// Ports:
//   CLK100MHZ, RESET (async, active high), SLOT_EN (slot start strobe)
//   CPU_REQ/CPU_WE/CPU_ADDR/CPU_DIN -> CPU_DOUT/CPU_ACK   CPU port
//   VID_ADDR -> VID_DOUT/VID_VALID                       video fetch port
//   CPU_SLOT   level, high for the whole of a CPU slot
//   RAM_ADDR/RAM_WE/RAM_DIN -> RAM_DOUT                  block-RAM side
//   OVERRUN    sticky slot-overrun flag
// Optional: define ARB_DBG_PORT_EN to add a debug port (DBG_*) that takes
//   over CPU slots left unused by the CPU.
module mem_slot_arbiter #(
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 8,
  parameter int RAM_LATENCY = 1    // 1..7, fits the 3-bit latency counter
) (
  input  logic              CLK100MHZ,
  input  logic              RESET,
  input  logic              SLOT_EN,
  input  logic              CPU_REQ,
  input  logic              CPU_WE,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [DATA_W-1:0] CPU_DIN,
  output logic [DATA_W-1:0] CPU_DOUT,
  output logic              CPU_ACK,
  input  logic [ADDR_W-1:0] VID_ADDR,
  output logic [DATA_W-1:0] VID_DOUT,
  output logic              VID_VALID,
  output logic              CPU_SLOT,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic              RAM_WE,
  output logic [DATA_W-1:0] RAM_DIN,
  input  logic [DATA_W-1:0] RAM_DOUT,
`ifdef ARB_DBG_PORT_EN
  input  logic              DBG_REQ,
  input  logic              DBG_WE,
  input  logic [ADDR_W-1:0] DBG_ADDR,
  input  logic [DATA_W-1:0] DBG_DIN,
  output logic [DATA_W-1:0] DBG_DOUT,
  output logic              DBG_ACK,
`endif
  output logic              OVERRUN
);

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT
  } state_t;

  state_t             state, state_n;
  logic               nxt_cpu, nxt_cpu_n;    // owner of the next slot (1 = CPU)
  logic               cur_cpu, cur_cpu_n;    // owner of the current slot
  logic               cur_we, cur_we_n;      // current access is a write
  logic               cur_live, cur_live_n;  // current slot issued a RAM access
  logic [CNT_W-1:0]   cnt, cnt_n;

  logic [ADDR_W-1:0]  ram_addr_n;
  logic               ram_we_n;
  logic [DATA_W-1:0]  ram_din_n;
  logic [DATA_W-1:0]  cpu_dout_n;
  logic               cpu_ack_n;
  logic [DATA_W-1:0]  vid_dout_n;
  logic               vid_valid_n;
  logic               cpu_slot_n;
  logic               overrun_n;

`ifdef ARB_DBG_PORT_EN
  logic               cur_dbg, cur_dbg_n;    // CPU slot lent to the debug port
  logic [DATA_W-1:0]  dbg_dout_n;
  logic               dbg_ack_n;
`endif

  always_ff @(posedge CLK100MHZ or posedge RESET) begin
    if (RESET) begin
      state     <= ST_IDLE;
      nxt_cpu   <= 1'b0;
      cur_cpu   <= 1'b0;
      cur_we    <= 1'b0;
      cur_live  <= 1'b0;
      cnt       <= '0;
      RAM_ADDR  <= '0;
      RAM_WE    <= 1'b0;
      RAM_DIN   <= '0;
      CPU_DOUT  <= '0;
      CPU_ACK   <= 1'b0;
      VID_DOUT  <= '0;
      VID_VALID <= 1'b0;
      CPU_SLOT  <= 1'b0;
      OVERRUN   <= 1'b0;
`ifdef ARB_DBG_PORT_EN
      cur_dbg   <= 1'b0;
      DBG_DOUT  <= '0;
      DBG_ACK   <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      nxt_cpu   <= nxt_cpu_n;
      cur_cpu   <= cur_cpu_n;
      cur_we    <= cur_we_n;
      cur_live  <= cur_live_n;
      cnt       <= cnt_n;
      RAM_ADDR  <= ram_addr_n;
      RAM_WE    <= ram_we_n;
      RAM_DIN   <= ram_din_n;
      CPU_DOUT  <= cpu_dout_n;
      CPU_ACK   <= cpu_ack_n;
      VID_DOUT  <= vid_dout_n;
      VID_VALID <= vid_valid_n;
      CPU_SLOT  <= cpu_slot_n;
      OVERRUN   <= overrun_n;
`ifdef ARB_DBG_PORT_EN
      cur_dbg   <= cur_dbg_n;
      DBG_DOUT  <= dbg_dout_n;
      DBG_ACK   <= dbg_ack_n;
`endif
    end
  end

  always_comb begin
    state_n     = state;
    nxt_cpu_n   = nxt_cpu;
    cur_cpu_n   = cur_cpu;
    cur_we_n    = cur_we;
    cur_live_n  = cur_live;
    cnt_n       = cnt;
    ram_addr_n  = RAM_ADDR;
    ram_we_n    = RAM_WE;
    ram_din_n   = RAM_DIN;
    cpu_dout_n  = CPU_DOUT;
    cpu_ack_n   = 1'b0;
    vid_dout_n  = VID_DOUT;
    vid_valid_n = 1'b0;
    cpu_slot_n  = CPU_SLOT;
    overrun_n   = OVERRUN;
`ifdef ARB_DBG_PORT_EN
    cur_dbg_n   = cur_dbg;
    dbg_dout_n  = DBG_DOUT;
    dbg_ack_n   = 1'b0;
`endif

    if (SLOT_EN) begin
      // A new slot always wins; an access still in flight is dropped
      // without its VALID/ACK and the overrun is recorded.
      if (state != ST_IDLE) overrun_n = 1'b1;
      state_n    = ST_ACCESS;
      cnt_n      = CNT_W'(RAM_LATENCY);
      nxt_cpu_n  = ~nxt_cpu;
      cur_cpu_n  = nxt_cpu;
      cur_we_n   = 1'b0;
      cur_live_n = 1'b0;
      ram_we_n   = 1'b0;
      cpu_slot_n = nxt_cpu;
`ifdef ARB_DBG_PORT_EN
      cur_dbg_n  = 1'b0;
`endif
      if (!nxt_cpu) begin
        ram_addr_n = VID_ADDR;
        cur_live_n = 1'b1;
      end else if (CPU_REQ) begin
        ram_addr_n = CPU_ADDR;
        ram_din_n  = CPU_DIN;
        ram_we_n   = CPU_WE;
        cur_we_n   = CPU_WE;
        cur_live_n = 1'b1;
      end
`ifdef ARB_DBG_PORT_EN
      else if (DBG_REQ) begin
        ram_addr_n = DBG_ADDR;
        ram_din_n  = DBG_DIN;
        ram_we_n   = DBG_WE;
        cur_we_n   = DBG_WE;
        cur_live_n = 1'b1;
        cur_dbg_n  = 1'b1;
      end
`endif
    end else begin
      case (state)
        ST_ACCESS: begin
          // Drop the write enable after one cycle; an unused CPU slot has
          // nothing to wait for.
          ram_we_n = 1'b0;
          state_n  = cur_live ? ST_WAIT : ST_IDLE;
        end
        ST_WAIT: begin
          cnt_n = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state_n = ST_IDLE;
            if (!cur_cpu) begin
              vid_dout_n  = RAM_DOUT;
              vid_valid_n = 1'b1;
            end
`ifdef ARB_DBG_PORT_EN
            else if (cur_dbg) begin
              dbg_ack_n = 1'b1;
              if (!cur_we) dbg_dout_n = RAM_DOUT;
            end
`endif
            else begin
              cpu_ack_n = 1'b1;
              if (!cur_we) cpu_dout_n = RAM_DOUT;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
